// File: rtl/se_conv_scheduler_if.sv
// Handshake/bus bundle between the SE conv scheduler and its environment
// (control, weight memory, input buffer, 1x1 engine, result stream).
interface se_conv_scheduler_if #(
  parameter int DATA_WIDTH   = 16,
  parameter int IN_CHANNELS  = 16,
  parameter int OUT_CHANNELS = 4
);
  localparam int WAW = (IN_CHANNELS*OUT_CHANNELS > 1) ? $clog2(IN_CHANNELS*OUT_CHANNELS) : 1;
  localparam int XAW = (IN_CHANNELS > 1) ? $clog2(IN_CHANNELS) : 1;
  localparam int CHW = (OUT_CHANNELS > 1) ? $clog2(OUT_CHANNELS) : 1;

  logic                  start;
  logic                  reload_w;
  logic                  busy;
  logic                  done;
  logic                  error;
  logic                  w_rd_en;
  logic [WAW-1:0]        w_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  x_rd_en;
  logic [XAW-1:0]        x_addr;
  logic [DATA_WIDTH-1:0] x_data;
  logic                  eng_rst;
  logic                  eng_load_kernel;
  logic [DATA_WIDTH-1:0] eng_in_data;
  logic                  eng_in_valid;
  logic [DATA_WIDTH-1:0] eng_out_data;
  logic                  eng_out_valid;
  logic                  res_valid;
  logic [CHW-1:0]        res_ch;
  logic [DATA_WIDTH-1:0] res_data;

  // scheduler side
  modport master (
    input  start, reload_w, w_data, x_data, eng_out_data, eng_out_valid,
    output busy, done, error, w_rd_en, w_addr, x_rd_en, x_addr,
           eng_rst, eng_load_kernel, eng_in_data, eng_in_valid,
           res_valid, res_ch, res_data
  );

  // environment side (control, memories, engine, result sink)
  modport slave (
    output start, reload_w, w_data, x_data, eng_out_data, eng_out_valid,
    input  busy, done, error, w_rd_en, w_addr, x_rd_en, x_addr,
           eng_rst, eng_load_kernel, eng_in_data, eng_in_valid,
           res_valid, res_ch, res_data
  );
endinterface

// File: rtl/se_conv_scheduler.sv
// Sequencer for the serial 1x1 conv engine in the SE path: optional engine
// reset + kernel load, one input vector stream, result collection with a
// watchdog that resets a stalled engine.
module se_conv_scheduler #(
  parameter int DATA_WIDTH   = 16,
  parameter int IN_CHANNELS  = 16,
  parameter int OUT_CHANNELS = 4,
  parameter int TIMEOUT      = 256
) (
  input  logic               clk,
  input  logic               rst,
  se_conv_scheduler_if.master bus
);
  localparam int WAW = (IN_CHANNELS*OUT_CHANNELS > 1) ? $clog2(IN_CHANNELS*OUT_CHANNELS) : 1;
  localparam int XAW = (IN_CHANNELS > 1) ? $clog2(IN_CHANNELS) : 1;
  localparam int CHW = (OUT_CHANNELS > 1) ? $clog2(OUT_CHANNELS) : 1;
  localparam int WDW = $clog2(TIMEOUT + 1);

  localparam logic [WAW-1:0] W_LAST  = WAW'(IN_CHANNELS*OUT_CHANNELS - 1);
  localparam logic [XAW-1:0] X_LAST  = XAW'(IN_CHANNELS - 1);
  localparam logic [CHW-1:0] CH_LAST = CHW'(OUT_CHANNELS - 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_ENG_RST, S_W_PRE, S_W_STREAM, S_X_PRE,
    S_X_STREAM, S_WAIT_OUT, S_DONE, S_ERR
  } state_t;

  state_t                r_state;
  logic                  r_wloaded;
  logic                  r_busy, r_done, r_error;
  logic                  r_w_rd_en, r_x_rd_en;
  logic [WAW-1:0]        r_w_addr;
  logic [XAW-1:0]        r_x_addr;
  logic                  r_eng_rst, r_load_k, r_eng_vld;
  logic                  r_src_w, r_src_x;   // which memory feeds eng_in_data this cycle
  logic [CHW-1:0]        r_cnt;
  logic [WDW-1:0]        r_wd;
  logic                  r_res_valid;
  logic [CHW-1:0]        r_res_ch;
  logic [DATA_WIDTH-1:0] r_res_data;
  logic                  w_last_strobe;

  // final result strobe of the run takes priority over a watchdog expiry
  assign w_last_strobe = bus.eng_out_valid && (r_cnt == CH_LAST);

  // sequencer FSM; every output is registered here
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_wloaded   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_w_rd_en   <= 1'b0;
      r_x_rd_en   <= 1'b0;
      r_w_addr    <= '0;
      r_x_addr    <= '0;
      r_eng_rst   <= 1'b0;
      r_load_k    <= 1'b0;
      r_eng_vld   <= 1'b0;
      r_src_w     <= 1'b0;
      r_src_x     <= 1'b0;
      r_cnt       <= '0;
      r_wd        <= '0;
      r_res_valid <= 1'b0;
      r_res_ch    <= '0;
      r_res_data  <= '0;
    end else begin
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_eng_rst   <= 1'b0;
      r_res_valid <= 1'b0;
      r_eng_vld   <= 1'b0;
      r_src_w     <= 1'b0;
      r_src_x     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_busy <= 1'b1;
            if (bus.reload_w || !r_wloaded) begin
              r_state   <= S_ENG_RST;
              r_eng_rst <= 1'b1;
              r_wloaded <= 1'b0;
            end else begin
              r_state   <= S_X_PRE;
              r_eng_vld <= 1'b1;          // wake word, data muxes to 0
            end
          end
        end
        S_ENG_RST: begin
          r_state  <= S_W_PRE;
          r_load_k <= 1'b1;               // wake cycle, no valid
        end
        S_W_PRE: begin
          r_state   <= S_W_STREAM;
          r_w_rd_en <= 1'b1;
          r_w_addr  <= '0;
        end
        S_W_STREAM: begin
          r_eng_vld <= r_w_rd_en;         // read data lands one cycle later
          r_src_w   <= r_w_rd_en;
          if (r_w_rd_en) begin
            if (r_w_addr == W_LAST) r_w_rd_en <= 1'b0;
            else                    r_w_addr  <= r_w_addr + 1'b1;
          end else begin
            // drain cycle: last weight is on the engine input now
            r_wloaded <= 1'b1;
            r_load_k  <= 1'b0;
            r_state   <= S_X_PRE;
            r_eng_vld <= 1'b1;
          end
        end
        S_X_PRE: begin
          r_state   <= S_X_STREAM;
          r_x_rd_en <= 1'b1;
          r_x_addr  <= '0;
        end
        S_X_STREAM: begin
          r_eng_vld <= r_x_rd_en;
          r_src_x   <= r_x_rd_en;
          if (r_x_rd_en) begin
            if (r_x_addr == X_LAST) r_x_rd_en <= 1'b0;
            else                    r_x_addr  <= r_x_addr + 1'b1;
          end else begin
            r_cnt   <= '0;
            r_wd    <= '0;
            r_state <= S_WAIT_OUT;
          end
        end
        S_WAIT_OUT: begin
          if (bus.eng_out_valid) begin
            r_res_valid <= 1'b1;
            r_res_ch    <= r_cnt;
            r_res_data  <= bus.eng_out_data;
            if (r_cnt == CH_LAST) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          if (!w_last_strobe) begin
            if (r_wd == WD_LAST) begin
              r_state   <= S_ERR;
              r_error   <= 1'b1;
              r_eng_rst <= 1'b1;
              r_wloaded <= 1'b0;
            end else begin
              r_wd <= r_wd + 1'b1;
            end
          end
        end
        S_DONE, S_ERR: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy            = r_busy;
  assign bus.done            = r_done;
  assign bus.error           = r_error;
  assign bus.w_rd_en         = r_w_rd_en;
  assign bus.w_addr          = r_w_addr;
  assign bus.x_rd_en         = r_x_rd_en;
  assign bus.x_addr          = r_x_addr;
  assign bus.eng_rst         = r_eng_rst;
  assign bus.eng_load_kernel = r_load_k;
  assign bus.eng_in_valid    = r_eng_vld;
  // memory read data is only valid in the cycle after the strobe, so it is
  // steered straight through rather than registered
  assign bus.eng_in_data     = r_src_w ? bus.w_data : (r_src_x ? bus.x_data : '0);
  assign bus.res_valid       = r_res_valid;
  assign bus.res_ch          = r_res_ch;
  assign bus.res_data        = r_res_data;
endmodule

// File: tb/tb_se_conv_scheduler.sv
// Randomized bench for se_conv_scheduler: memories and engine modelled here,
// expectations derived from the scheduling rules (address order, word order,
// result indexing, cycle offsets).
module tb_se_conv_scheduler;
  localparam int DW = 16;
  localparam int IC = 16;
  localparam int OC = 4;
  localparam int TO = 256;
  localparam int NW = IC*OC;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  se_conv_scheduler_if #(.DATA_WIDTH(DW), .IN_CHANNELS(IC), .OUT_CHANNELS(OC)) bus();

  se_conv_scheduler #(.DATA_WIDTH(DW), .IN_CHANNELS(IC), .OUT_CHANNELS(OC), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [DW-1:0] wmem [NW];
  logic [DW-1:0] xmem [IC];

  // 1-cycle-latency memories
  always @(posedge clk) begin
    if (bus.w_rd_en) bus.w_data <= wmem[bus.w_addr];
    if (bus.x_rd_en) bus.x_data <= xmem[bus.x_addr];
  end

  int checks = 0;
  int errors = 0;

  // per-run observations
  int cyc, n_rst, n_done, n_err, err_cyc, err_rst, x_last, w_first, w_last, busy_gap;
  bit timed_out;
  int waq[$], xaq[$];
  logic [DW-1:0] kq[$], xq[$], rdq[$], edq[$];
  int rcq[$], ecq[$];

  function automatic logic [63:0] all_outs();
    return 64'({bus.busy, bus.done, bus.error, bus.w_rd_en, bus.x_rd_en, bus.w_addr,
                bus.x_addr, bus.eng_rst, bus.eng_load_kernel, bus.eng_in_valid,
                bus.eng_in_data, bus.res_valid, bus.res_ch, bus.res_data});
  endfunction

  task automatic fill_mem();
    for (int i = 0; i < NW; i++) wmem[i] = DW'($urandom);
    for (int i = 0; i < IC; i++) xmem[i] = DW'($urandom);
  endtask

  // mode 0 normal, 1 engine silent, 2 start spam, 3 stray out_valid in X stream
  task automatic run(input bit rl, input int mode, input int stop_wa);
    int nx, nstr;
    bit armed, fin;
    waq.delete(); xaq.delete(); kq.delete(); xq.delete();
    rdq.delete(); edq.delete(); rcq.delete(); ecq.delete();
    n_rst = 0; n_done = 0; n_err = 0; err_cyc = -1; err_rst = 0;
    x_last = -1; w_first = -1; w_last = -1; busy_gap = 0; timed_out = 0;
    nx = 0; nstr = 0; armed = 0; fin = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.reload_w = rl; cyc = 0;
    while (!fin) begin
      @(negedge clk);
      cyc++;
      bus.start = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.reload_w = (mode == 2) ? 1'($urandom_range(0, 1)) : rl;
      bus.eng_out_valid = 1'b0;
      if (armed && mode != 1 && nstr < OC && $urandom_range(0, 2) != 0) begin
        bus.eng_out_valid = 1'b1;
        bus.eng_out_data = DW'($urandom);
        edq.push_back(bus.eng_out_data);
        ecq.push_back(nstr);
        nstr++;
      end else if (mode == 3 && nx == 5) begin
        bus.eng_out_valid = 1'b1;
        bus.eng_out_data = DW'($urandom);
      end else begin
        bus.eng_out_data = DW'($urandom);
      end
      // observe
      if (!bus.busy) busy_gap++;
      if (bus.eng_rst) n_rst++;
      if (bus.w_rd_en) begin
        waq.push_back(int'(bus.w_addr));
        if (w_first < 0) w_first = cyc;
        w_last = cyc;
      end
      if (bus.x_rd_en) xaq.push_back(int'(bus.x_addr));
      if (bus.eng_in_valid) begin
        if (bus.eng_load_kernel) kq.push_back(bus.eng_in_data);
        else begin xq.push_back(bus.eng_in_data); x_last = cyc; nx++; end
      end
      if (bus.res_valid) begin rcq.push_back(int'(bus.res_ch)); rdq.push_back(bus.res_data); end
      if (bus.done) n_done++;
      if (bus.error) begin n_err++; err_cyc = cyc; err_rst = bus.eng_rst; end
      if (nx == IC + 1) armed = 1;
      if (bus.done || bus.error) fin = 1;
      if (stop_wa >= 0 && bus.w_rd_en && int'(bus.w_addr) == stop_wa) fin = 1;
      if (cyc >= 1500) begin timed_out = 1; fin = 1; end
    end
    bus.start = 1'b0;
    bus.eng_out_valid = 1'b0;
    checks++;
    if (timed_out) begin
      errors++;
      $display("FAIL run_timeout: no done/error/stop after %0d cycles, required within 1500", cyc);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (all_outs() !== 64'd0) begin
      errors++; $display("FAIL reset_outputs: got %h, required 0", all_outs());
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    checks++;
    if (all_outs() !== 64'd0) begin
      errors++; $display("FAIL idle_outputs: got %h, required 0", all_outs());
    end
  endtask

  task automatic test_first_run();
    bit ok;
    fill_mem();
    run(1'b0, 0, -1);
    checks++;
    if (n_rst !== 1) begin errors++; $display("FAIL first_eng_rst: got %0d pulses, required 1", n_rst); end
    ok = (waq.size() == NW) && (w_last - w_first == NW - 1);
    for (int i = 0; i < waq.size(); i++) if (waq[i] != i) ok = 0;
    checks++;
    if (!ok) begin errors++; $display("FAIL first_w_addr: got %0d reads over %0d cycles, required 0..%0d back-to-back", waq.size(), w_last - w_first + 1, NW - 1); end
    ok = (kq.size() == NW);
    for (int i = 0; i < kq.size() && i < NW; i++) if (kq[i] !== wmem[i]) ok = 0;
    checks++;
    if (!ok) begin errors++; $display("FAIL first_kernel_words: got %0d words, required %0d matching wmem", kq.size(), NW); end
    ok = (xq.size() == IC + 1) && (xq[0] === '0);
    for (int i = 1; i < xq.size() && i <= IC; i++) if (xq[i] !== xmem[i-1]) ok = 0;
    checks++;
    if (!ok) begin errors++; $display("FAIL first_x_words: got %0d words, required wake 0 + %0d xmem words", xq.size(), IC); end
    ok = (rcq.size() == OC) && (edq.size() == OC);
    for (int i = 0; i < rcq.size() && i < edq.size(); i++) if (rcq[i] != ecq[i] || rdq[i] !== edq[i]) ok = 0;
    checks++;
    if (!ok) begin errors++; $display("FAIL first_results: got %0d results, required %0d ch 0..%0d with engine data", rcq.size(), OC, OC - 1); end
    checks++;
    if (n_done !== 1 || n_err !== 0) begin errors++; $display("FAIL first_done: got done=%0d error=%0d, required 1/0", n_done, n_err); end
    checks++;
    if (busy_gap !== 0) begin errors++; $display("FAIL first_busy: got %0d idle cycles during run, required 0", busy_gap); end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL first_busy_fall: got %b after done, required 0", bus.busy); end
  endtask

  task automatic test_no_reload();
    bit ok;
    fill_mem();
    run(1'b0, 0, -1);
    checks++;
    if (n_rst !== 0 || waq.size() !== 0) begin errors++; $display("FAIL noreload_weights: got eng_rst=%0d w_reads=%0d, required 0/0", n_rst, waq.size()); end
    ok = (xaq.size() == IC);
    for (int i = 0; i < xaq.size(); i++) if (xaq[i] != i) ok = 0;
    for (int i = 1; i < xq.size() && i <= IC; i++) if (xq[i] !== xmem[i-1]) ok = 0;
    checks++;
    if (!ok) begin errors++; $display("FAIL noreload_x_stream: got %0d reads, required 0..%0d with matching data", xaq.size(), IC - 1); end
    checks++;
    if (x_last !== IC + 2) begin errors++; $display("FAIL noreload_latency: got last input at cycle %0d, required %0d", x_last, IC + 2); end
    ok = (rcq.size() == OC);
    for (int i = 0; i < rcq.size() && i < edq.size(); i++) if (rcq[i] != i || rdq[i] !== edq[i]) ok = 0;
    checks++;
    if (!ok || n_done !== 1) begin errors++; $display("FAIL noreload_results: got %0d results done=%0d, required %0d/1", rcq.size(), n_done, OC); end
  endtask

  task automatic test_timeout();
    bit ok;
    run(1'b0, 1, -1);
    checks++;
    if (n_err !== 1 || n_done !== 0) begin errors++; $display("FAIL timeout_pulse: got error=%0d done=%0d, required 1/0", n_err, n_done); end
    checks++;
    if (err_cyc - (x_last + 1) !== TO) begin errors++; $display("FAIL timeout_delay: got %0d cycles after WAIT_OUT entry, required %0d", err_cyc - (x_last + 1), TO); end
    checks++;
    if (err_rst !== 1) begin errors++; $display("FAIL timeout_eng_rst: got %0d in error cycle, required 1", err_rst); end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL timeout_busy_fall: got %b, required 0", bus.busy); end
    fill_mem();
    run(1'b0, 0, -1);
    ok = (n_rst == 1) && (kq.size() == NW);
    for (int i = 0; i < kq.size() && i < NW; i++) if (kq[i] !== wmem[i]) ok = 0;
    checks++;
    if (!ok || n_done !== 1) begin errors++; $display("FAIL timeout_reload: got eng_rst=%0d words=%0d done=%0d, required 1/%0d/1", n_rst, kq.size(), n_done, NW); end
  endtask

  task automatic test_start_spam();
    int extra;
    bit ok;
    run(1'b0, 2, -1);
    ok = (rcq.size() == OC);
    for (int i = 0; i < rcq.size() && i < edq.size(); i++) if (rcq[i] != i || rdq[i] !== edq[i]) ok = 0;
    checks++;
    if (!ok || n_done !== 1) begin errors++; $display("FAIL spam_one_done: got %0d results done=%0d, required %0d/1", rcq.size(), n_done, OC); end
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) extra++;
    end
    checks++;
    if (extra !== 0) begin errors++; $display("FAIL spam_no_requeue: got %0d busy/done cycles after run, required 0", extra); end
  endtask

  task automatic test_async_reset();
    bit ok;
    run(1'b1, 0, 20);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (all_outs() !== 64'd0 || n_done !== 0 || n_err !== 0) begin
      errors++; $display("FAIL async_reset: got outs=%h done=%0d err=%0d, required 0/0/0", all_outs(), n_done, n_err);
    end
    @(negedge clk); @(negedge clk); rst = 1'b0;
    fill_mem();
    run(1'b0, 0, -1);
    ok = (n_rst == 1) && (waq.size() == NW) && (kq.size() == NW);
    for (int i = 0; i < waq.size(); i++) if (waq[i] != i) ok = 0;
    for (int i = 0; i < kq.size() && i < NW; i++) if (kq[i] !== wmem[i]) ok = 0;
    checks++;
    if (!ok || n_done !== 1) begin errors++; $display("FAIL async_reset_reload: got eng_rst=%0d reads=%0d done=%0d, required 1/%0d/1", n_rst, waq.size(), n_done, NW); end
  endtask

  task automatic test_stray_out_valid();
    bit ok;
    fill_mem();
    run(1'b0, 3, -1);
    ok = (rcq.size() == OC);
    for (int i = 0; i < rcq.size() && i < edq.size(); i++) if (rcq[i] != i || rdq[i] !== edq[i]) ok = 0;
    checks++;
    if (!ok || n_done !== 1) begin errors++; $display("FAIL stray_ignored: got %0d results done=%0d, required %0d/1 indexed from 0", rcq.size(), n_done, OC); end
  endtask

  initial begin
    bus.start = 1'b0; bus.reload_w = 1'b0;
    bus.eng_out_valid = 1'b0; bus.eng_out_data = '0;
    bus.w_data = '0; bus.x_data = '0;
    fill_mem();
    test_reset();
    test_first_run();
    test_no_reload();
    test_timeout();
    test_start_spam();
    test_async_reset();
    test_stray_out_valid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
